// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a FIFO_DEPTH-entry transmit FIFO and per-frame framing (5-8 data bits, parity, 1/2 stop).
// Optional feature macro UART_TX_CTS_EN adds a synchronised active-low cts_n that gates frame start.
module uart_tx_fifo_param #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_en,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          odd_parity,
  input  logic                          two_stop,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          busy,
  output logic                          tx_out
);
  // Push handshake: a byte is written on any clk edge where wr_valid && wr_ready; wr_ready = !fifo_full.
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [7:0]          shift_q, shift_d;
  logic [1:0]          nbits_q, nbits_d;
  logic                par_en_q, par_en_d;
  logic                two_stop_q, two_stop_d;
  logic                par_q, par_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic                stop_q, stop_d;

  logic                push, pop, tick, can_start, cts_ok;
  logic [7:0]          head, mask;
  logic [2:0]          last_bit;

`ifdef UART_TX_CTS_EN
  logic cts_s1_q, cts_s2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_n;
      cts_s2_q <= cts_s1_q;
    end
  end
  assign cts_ok = !cts_s2_q;
`else
  assign cts_ok = 1'b1;
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign wr_ready   = !fifo_full;
  assign busy       = (state_q != IDLE);
  assign push       = wr_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];
  assign mask       = 8'hFF >> (2'd3 - data_bits);
  assign tick       = (cnt_q == div_q);
  assign can_start  = tx_en && !fifo_empty && cts_ok;
  assign last_bit   = {1'b0, nbits_q} + 3'd4;

  always_comb begin
    tx_out = 1'b1;
    case (state_q)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift_q[0];
      PARITY:  tx_out = par_q;
      default: tx_out = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    par_d      = par_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    pop        = 1'b0;

    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      IDLE:   if (can_start) pop = 1'b1;
      START:  if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == last_bit) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP: begin
        if (tick) begin
          if (stop_q == two_stop_q) begin
            if (can_start) pop = 1'b1;
            else           state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Framing is captured at pop time so mid-frame config changes only hit the next frame.
    if (pop) begin
      state_d    = START;
      shift_d    = head;
      nbits_d    = data_bits;
      par_en_d   = parity_en;
      two_stop_d = two_stop;
      div_d      = baud_div;
      par_d      = ^(head & mask) ^ odd_parity;
      cnt_d      = '0;
      bit_d      = '0;
      stop_d     = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      par_q      <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      par_q      <= par_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: framing vector table, FIFO fill/drain, same-edge push/pop, async reset, optional CTS.
module tb_uart_tx_fifo_param;
  logic        clk, rst_n, tx_en, parity_en, odd_parity, two_stop, wr_valid;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [7:0]  wr_data;
  logic        wr_ready, fifo_empty, fifo_full, busy, tx_out;
  logic [3:0]  fifo_count;
`ifdef UART_TX_CTS_EN
  logic        cts_n;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic       aborted = 1'b0;

  uart_tx_fifo_param #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .baud_div(baud_div),
    .data_bits(data_bits), .parity_en(parity_en), .odd_parity(odd_parity),
    .two_stop(two_stop), .wr_valid(wr_valid), .wr_data(wr_data),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .wr_ready(wr_ready), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .busy(busy), .tx_out(tx_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge rst_n) aborted = 1'b1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] data_mask(input logic [1:0] db);
    logic [7:0] m;
    m = 8'hFF;
    return m >> (3 - db);
  endfunction

  // driver tasks
  task automatic set_cfg(input logic [1:0] db, input logic pe, input logic odd,
                         input logic ts, input logic [15:0] div);
    @(negedge clk);
    data_bits = db; parity_en = pe; odd_parity = odd; two_stop = ts; baud_div = div;
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = d;
    if (wr_ready) exp_q.push_back(d & data_mask(data_bits));
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    while ((busy || !fifo_empty) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < max_cycles), 1);
  endtask

  // scoreboard monitor: decodes every frame on the line and compares with exp_q
  initial begin : monitor
    logic [7:0] got, exp;
    logic       par_got, stop_ok, pe, odd, ts;
    int         b, n;
    forever begin
      @(negedge clk);
      if (rst_n && tx_out === 1'b0) begin
        b = int'(baud_div) + 1;
        n = int'(data_bits) + 5;
        pe = parity_en; odd = odd_parity; ts = two_stop;
        aborted = 1'b0; got = '0; par_got = 1'b0; stop_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
          repeat (b) @(negedge clk);
          got[i] = tx_out;
        end
        if (pe) begin
          repeat (b) @(negedge clk);
          par_got = tx_out;
        end
        for (int s = 0; s < (ts ? 2 : 1); s++) begin
          repeat (b) @(negedge clk);
          if (tx_out !== 1'b1) stop_ok = 1'b0;
        end
        if (aborted) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          check("mon_unexpected_frame", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("mon_byte", got, exp);
          if (pe) check("mon_parity", par_got, (^exp) ^ odd);
          check("mon_stop", stop_ok, 1);
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  db;
    logic        pe;
    logic        odd;
    logic        ts;
    logic [15:0] div;
    logic [7:0]  data;
    logic [11:0] frame;   // line bits, index 0 = start bit
    int          nb;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int b, run;
    logic stayed_high;

    vecs[0] = '{2'd3, 1'b0, 1'b0, 1'b0, 16'd3, 8'hA5, 12'b001101001010, 10};
    vecs[1] = '{2'd0, 1'b1, 1'b1, 1'b1, 16'd0, 8'h1F, 12'b000110111110, 9};
    vecs[2] = '{2'd2, 1'b1, 1'b0, 1'b0, 16'd1, 8'h3C, 12'b001001111000, 10};
    vecs[3] = '{2'd1, 1'b1, 1'b1, 1'b1, 16'd2, 8'hFF, 12'b001111111110, 10};
    vecs[4] = '{2'd3, 1'b1, 1'b0, 1'b1, 16'd0, 8'h96, 12'b110100101100, 12};
    vecs[5] = '{2'd0, 1'b0, 1'b0, 1'b0, 16'd1, 8'h2A, 12'b000001010100, 7};

    rst_n = 1'b0; tx_en = 1'b1; wr_valid = 1'b0; wr_data = '0;
    data_bits = 2'd3; parity_en = 1'b0; odd_parity = 1'b0; two_stop = 1'b0; baud_div = 16'd3;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_tx_out", tx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_wr_ready", wr_ready, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // framing table: push into an empty FIFO, check latency, each line bit and frame length
    foreach (vecs[v]) begin
      set_cfg(vecs[v].db, vecs[v].pe, vecs[v].odd, vecs[v].ts, vecs[v].div);
      b = int'(vecs[v].div) + 1;
      push_byte(vecs[v].data);
      @(negedge clk);
      check("pre_start_high", tx_out, 1);
      check("count_after_push", fifo_count, 1);
      @(negedge clk);
      check("count_after_pop", fifo_count, 0);
      for (int i = 0; i < vecs[v].nb; i++) begin
        if (i > 0) repeat (b) @(negedge clk);
        check($sformatf("v%0d_bit%0d", v, i), tx_out, vecs[v].frame[i]);
      end
      repeat (b - 1) @(negedge clk);
      check("busy_last_clock", busy, 1);
      @(negedge clk);
      check("busy_fell", busy, 0);
      check("idle_high", tx_out, 1);
    end

    // fill while disabled, overflow drop, then back-to-back drain
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd0);
    tx_en = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    check("fill_full", fifo_full, 1);
    check("fill_count", fifo_count, 8);
    check("fill_wr_ready", wr_ready, 0);
    push_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    check("drop_count", fifo_count, 8);
    tx_en = 1'b1;
    run = 0;
    for (int i = 0; i < 5 && !busy; i++) @(negedge clk);
    check("drain_started", busy, 1);
    while (busy && run < 200) begin
      run++;
      @(negedge clk);
    end
    check("b2b_busy_run", run, 80);
    check("drain_empty", fifo_empty, 1);

    // push on the same edge as a STOP->START pop leaves the count unchanged
    tx_en = 1'b0;
    push_byte(8'h3A);
    push_byte(8'hC5);
    @(negedge clk);
    tx_en = 1'b1;
    repeat (10) @(negedge clk);
    check("same_edge_count_before", fifo_count, 1);
    wr_valid = 1'b1; wr_data = 8'h6E;
    exp_q.push_back(8'h6E);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    check("same_edge_count_after", fifo_count, 1);
    check("no_idle_gap", tx_out, 0);
    wait_idle("same_edge_drain", 200);

`ifdef UART_TX_CTS_EN
    @(negedge clk);
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    push_byte(8'h55);
    stayed_high = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
    end
    check("cts_blocked", stayed_high, 1);
    cts_n = 1'b0;
    @(negedge clk);
    check("cts_sync1", tx_out, 1);
    @(negedge clk);
    check("cts_sync2", tx_out, 1);
    @(negedge clk);
    check("cts_start", tx_out, 0);
    repeat (4) @(negedge clk);
    cts_n = 1'b1;
    wait_idle("cts_frame_done", 100);
    cts_n = 1'b0;
    repeat (3) @(negedge clk);
`endif

    // async reset mid-DATA truncates the frame and empties the FIFO
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd3);
    push_byte(8'h00);
    repeat (8) @(negedge clk);
    check("mid_data_low", tx_out, 0);
    check("mid_data_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_out", tx_out, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_empty", fifo_empty, 1);
    check("async_rst_count", fifo_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stayed_high = 1'b1;
    repeat (45) begin
      @(negedge clk);
      if (tx_out !== 1'b1) stayed_high = 1'b0;
    end
    check("post_rst_line_high", stayed_high, 1);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
